i2c_txn_arbiter: RTL and testbench

//  Shares one I2C master engine among N_REQ requesters, one full transaction at a time.
//  - Picks one requester by round-robin and drives the master's rst/rw/data_in.
//  - Tracks the master's 4-bit state output to detect when the transaction is done.
//  - Returns read data and a done pulse to the requester that won.
//  - Sits between the system-side clients and the i2c master (sclk/sda stay on the master).

---
 rtl/i2c_txn_arbiter_pkg.sv | 28 ++
 rtl/i2c_txn_arbiter_rr_pick.sv | 39 +++
 rtl/i2c_txn_arbiter.sv | 176 +++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared definitions for the I2C transaction arbiter: master state codes,
// arbiter FSM encoding and transfer direction constants.
package i2c_pkg;

  localparam logic [3:0] I2C_ST_IDLE     = 4'd0;
  localparam logic [3:0] I2C_ST_START    = 4'd1;
  localparam logic [3:0] I2C_ST_ADDR     = 4'd2;
  localparam logic [3:0] I2C_ST_RW       = 4'd3;
  localparam logic [3:0] I2C_ST_ADDR_ACK = 4'd4;
  localparam logic [3:0] I2C_ST_WDATA    = 4'd5;
  localparam logic [3:0] I2C_ST_RDATA    = 4'd6;
  localparam logic [3:0] I2C_ST_DATA_ACK = 4'd7;
  localparam logic [3:0] I2C_ST_PRE_STOP = 4'd8;
  localparam logic [3:0] I2C_ST_STOP     = 4'd9;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_GRANT  = 3'd1,
    ARB_LAUNCH = 3'd2,
    ARB_RUN    = 3'd3,
    ARB_FINISH = 3'd4,
    ARB_GAP    = 3'd5
  } arb_state_t;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester with req high,
// searching upward from ptr+1 and wrapping, as a one-hot vector and an index.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  logic          found;
  logic [IW-1:0] cand;
  logic [IW-1:0] win;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    win   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    onehot_o = '0;
    if (found) onehot_o[win] = 1'b1;
  end

  assign any_o = found;
  assign idx_o = win;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master among N_REQ requesters, one whole transaction at a time.
// Define I2C_ARB_TIMEOUT_EN to add a per-transaction watchdog that aborts with err.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned MIN_IDLE       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   rw,
  input  logic [8*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic               busy,
  output logic               err,
  output logic               m_rst,
  output logic               m_rw,
  output logic [7:0]         m_data_in,
  input  logic [7:0]         m_data_out,
  input  logic [3:0]         m_state,
  output arb_state_t         dbg_state
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned GW = $clog2(MIN_IDLE);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
  end
  if (MIN_IDLE < 2) begin : g_bad_min_idle
  end

  arb_state_t         state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic [7:0]         rdata_q;
  logic               m_rst_q;
  logic               m_rw_q;
  logic [7:0]         m_data_in_q;
  logic               seen_stop_q;
  logic [GW-1:0]      gap_q;

  logic               pick_any;
  logic [IW-1:0]      pick_idx;
  logic [N_REQ-1:0]   pick_onehot;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end
`endif

  // Handshake: req is a level held by the requester until its done pulse;
  // gnt stays high for the owned transaction, done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      m_rst_q     <= 1'b1;
      m_rw_q      <= DIR_WRITE;
      m_data_in_q <= '0;
      seen_stop_q <= 1'b0;
      gap_q       <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            win_q       <= pick_idx;
            gnt_q       <= pick_onehot;
            m_rw_q      <= rw[pick_idx];
            m_data_in_q <= wdata[{pick_idx, 3'b000} +: 8];
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          m_rst_q     <= 1'b0;
          seen_stop_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_q        <= '0;
`endif
          state_q     <= ARB_LAUNCH;
        end
        ARB_LAUNCH: begin
          if (m_state != I2C_ST_IDLE) begin
            if (m_state == I2C_ST_STOP) seen_stop_q <= 1'b1;
            state_q <= ARB_RUN;
          end
        end
        ARB_RUN: begin
          if (m_state == I2C_ST_STOP) seen_stop_q <= 1'b1;
          // Completion is the master's return to idle after it has shown STOP.
          if (seen_stop_q && m_state == I2C_ST_IDLE) begin
            rdata_q <= m_data_out;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            m_rst_q <= 1'b1;
            ptr_q   <= win_q;
            state_q <= ARB_FINISH;
          end
        end
        ARB_FINISH: begin
          done_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          gap_q   <= GW'(MIN_IDLE - 1);
          state_q <= ARB_GAP;
        end
        ARB_GAP: begin
          if (gap_q == '0) state_q <= ARB_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= ARB_IDLE;
      endcase

`ifdef I2C_ARB_TIMEOUT_EN
      // Placed after the case so an expiring watchdog overrides normal progress.
      if (state_q == ARB_LAUNCH || state_q == ARB_RUN) begin
        if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          done_q  <= gnt_q;
          gnt_q   <= '0;
          m_rst_q <= 1'b1;
          ptr_q   <= win_q;
          state_q <= ARB_FINISH;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != ARB_IDLE);
  assign m_rst     = m_rst_q;
  assign m_rw      = m_rw_q;
  assign m_data_in = m_data_in_q;
  assign dbg_state = state_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: behavioural I2C master, random
// requesters, round-robin reference model and a done/rdata scoreboard.
module tb_i2c_txn_arbiter;

  localparam int N        = 4;
  localparam int MIN_IDLE = 8;
  localparam int TMO      = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   rw  = '0;
  logic [8*N-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [7:0]     rdata;
  logic           busy;
  logic           err;
  logic           m_rst;
  logic           m_rw;
  logic [7:0]     m_data_in;
  logic [7:0]     m_data_out = 8'h00;
  logic [3:0]     m_state = 4'd0;
  logic [2:0]     dbg_state;

  i2c_txn_arbiter #(
    .N_REQ          (N),
    .MIN_IDLE       (MIN_IDLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rw         (rw),
    .wdata      (wdata),
    .gnt        (gnt),
    .done       (done),
    .rdata      (rdata),
    .busy       (busy),
    .err        (err),
    .m_rst      (m_rst),
    .m_rw       (m_rw),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_state    (m_state),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0]     exp_q[$];      // read bytes the master model presented at completion
  int             exp_idx_q[$];  // owners of transactions in flight
  int             grant_log[$];
  int             model_ptr = 0;
  logic [N-1:0]   req_s, rw_s;
  logic [8*N-1:0] wdata_s;
  int             cyc = 0;
  logic [N-1:0]   gnt_prev = '0;
  logic           mrst_prev = 1'b1;
  int             mrst_hi = 0;
  logic           exp_rw = 1'b0;
  logic [7:0]     exp_wd = 8'h00;
  int             gnt_cyc = 0;
  int             last_done_cyc = 0;
  logic [7:0]     last_rdata = 8'h00;
  int             done_cnt = 0;
  bit             exp_err_mode = 1'b0;
  bit             hang = 1'b0;
  bit             force_en = 1'b0;
  logic [7:0]     force_byte = 8'h00;
  bit [N-1:0]     pending = '0;

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    req_s   <= req;
    rw_s    <= rw;
    wdata_s <= wdata;
    cyc     <= cyc + 1;
  end

  // ---------------- behavioural I2C master ----------------
  bit m_fin = 1'b0;
  int m_dly = 0;
  always @(posedge clk) begin
    #1;
    if (m_rst !== 1'b0) begin
      m_state = 4'd0;
      m_fin   = 1'b0;
      m_dly   = $urandom_range(2);
    end else if (!m_fin) begin
      if (m_dly > 0) m_dly--;
      else if (hang && m_state == 4'd3) m_dly = 0;
      else if (m_state == 4'd9) begin
        m_state = 4'd0;
        m_fin   = 1'b1;
        exp_q.push_back(m_data_out);
      end else begin
        m_state = m_state + 4'd1;
        m_dly   = $urandom_range(2);
        if (m_state == 4'd5) m_data_out = force_en ? force_byte : 8'($urandom);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int w, idx;
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_idx_q.delete();
      model_ptr = 0;
      gnt_prev  = '0;
      mrst_prev = 1'b1;
      mrst_hi   = MIN_IDLE;
    end else begin
      if (gnt_prev == '0 && gnt != '0) begin
        w = rr_model(req_s, model_ptr);
        check("grant_onehot", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
        check("grant_while_owned", 32'(exp_idx_q.size()), 32'd0);
        check("busy_at_grant", 32'(busy), 32'd1);
        if (w >= 0) begin
          exp_idx_q.push_back(w);
          exp_rw = rw_s[w];
          exp_wd = wdata_s[w*8 +: 8];
          grant_log.push_back(w);
          gnt_cyc = cyc;
        end
      end
      if (m_rst == 1'b0 && gnt != '0) begin
        check("m_rw", 32'(m_rw), 32'(exp_rw));
        check("m_data_in", 32'(m_data_in), 32'(exp_wd));
      end
      if (m_rst == 1'b0 && mrst_prev == 1'b1)
        check("min_idle_gap", 32'(mrst_hi >= MIN_IDLE), 32'd1);
      mrst_hi = m_rst ? mrst_hi + 1 : 0;
      if (done != '0) begin
        if (exp_idx_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          idx = exp_idx_q.pop_front();
          check("done_onehot", 32'(done), 32'd1 << idx);
          check("gnt_clear_at_done", 32'(gnt), 32'd0);
          if (exp_err_mode) begin
            check("timeout_rdata", 32'(rdata), 32'd0);
            check("timeout_err", 32'(err), 32'd1);
          end else if (exp_q.size() == 0) begin
            check("rdata_available", 32'(exp_q.size()), 32'd1);
          end else begin
            check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
            check("err_on_done", 32'(err), 32'd0);
          end
          model_ptr     = idx;
          last_rdata    = rdata;
          last_done_cyc = cyc;
          done_cnt++;
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end
      gnt_prev  = gnt;
      mrst_prev = m_rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise_req(input int i, input logic r, input logic [7:0] d);
    req[i]          = 1'b1;
    rw[i]           = r;
    wdata[i*8 +: 8] = d;
    pending[i]      = 1'b1;
  endtask

  task automatic drive_cycle(input int raise_pct, input bit drop_early);
    @(negedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (pending[i] && done[i]) begin
        pending[i] = 1'b0;
        req[i]     = 1'b0;
      end else if (drop_early && req[i] && gnt[i] && m_state >= 4'd4) begin
        req[i] = 1'b0;
      end else if (!pending[i] && raise_pct > 0 && $urandom_range(99) < raise_pct) begin
        raise_req(i, 1'($urandom_range(1)), 8'($urandom));
      end
    end
  endtask

  task automatic drain(input string name, input int budget, input bit drop_early);
    int n = 0;
    while (pending != '0 && n < budget) begin
      drive_cycle(0, drop_early);
      n++;
    end
    check(name, 32'(pending), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int fair_tab[5] = '{1, 2, 3, 0, 1};
  int n;
  int base;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_m_rst", 32'(m_rst), 32'd1);
    check("rst_m_rw", 32'(m_rw), 32'd0);
    check("rst_m_data_in", 32'(m_data_in), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // single write from requester 1
    #2 raise_req(1, 1'b0, 8'hA5);
    @(negedge clk);
    check("t1_grant_next_cycle", 32'(gnt), 32'h2);
    drain("t1_done", 300, 1'b0);

    // read from requester 2 with a known byte
    force_en   = 1'b1;
    force_byte = 8'h3C;
    raise_req(2, 1'b1, 8'h00);
    drain("t2_done", 300, 1'b0);
    check("t2_rdata", 32'(last_rdata), 32'h3C);
    force_en = 1'b0;

    // requester 0 drops req mid-transaction
    base = done_cnt;
    raise_req(0, 1'b0, 8'h5A);
    drain("t4_done", 300, 1'b1);
    check("t4_done_count", 32'(done_cnt - base), 32'd1);

    // fairness from a fresh pointer
    do_reset();
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 5 && n < 600) begin
      drive_cycle(100, 1'b0);
      n++;
    end
    drain("t3_drain", 600, 1'b0);
    check("t3_grant_count", 32'(grant_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("t3_order", 32'(grant_log[k]), 32'(fair_tab[k]));

    // random traffic
    repeat (6) begin
      bit drop;
      drop = 1'($urandom_range(1));
      repeat (100) drive_cycle(15, drop);
    end
    drain("rand_drain", 800, 1'b0);

    // hung master, then reset mid-transaction
    hang = 1'b1;
    raise_req(3, 1'b1, 8'h77);
    n = 0;
    while (gnt[3] !== 1'b1 && n < 50) begin
      drive_cycle(0, 1'b0);
      n++;
    end
    check("t5_granted", 32'(gnt), 32'h8);
    repeat (20) drive_cycle(0, 1'b0);
`ifndef I2C_ARB_TIMEOUT_EN
    repeat (150) drive_cycle(0, 1'b0);
    check("t6_hung_busy", 32'(busy), 32'd1);
    check("t6_hung_gnt", 32'(gnt), 32'h8);
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t5_async_gnt", 32'(gnt), 32'd0);
    check("t5_async_m_rst", 32'(m_rst), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_done", 32'(done), 32'd0);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    base = done_cnt;
    drain("t5_regrant", 300, 1'b0);
    check("t5_regrant_done", 32'(done_cnt - base), 32'd1);

`ifdef I2C_ARB_TIMEOUT_EN
    exp_err_mode = 1'b1;
    hang         = 1'b1;
    raise_req(2, 1'b0, 8'h11);
    drain("t6_timeout_done", 300, 1'b0);
    check("t6_timeout_latency", 32'((last_done_cyc - gnt_cyc) >= TMO && (last_done_cyc - gnt_cyc) <= TMO + 2), 32'd1);
    exp_err_mode = 1'b0;
    hang         = 1'b0;
    repeat (20) drive_cycle(0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL global_timeout: actual=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
